// File: rtl/vram_fetcher_pkg.sv
// Shared definitions for the video-memory read fetcher.
//   - fetch_state_t   : FSM state encoding, visible on the fetcher's debug port
//   - WORD_WIDTH      : width of one memory word
//   - ADDR_WIDTH      : width of a memory address
//   - FRAME_*         : default frame-region layout, also used by the VGA
//                       pixel generator so both sides agree on the frame shape
package vram_fetcher_pkg;

    localparam int WORD_WIDTH = 16;
    localparam int ADDR_WIDTH = 16;

    localparam logic [ADDR_WIDTH-1:0] FRAME_BASE_ADDR      = 16'hC000;
    localparam int                    FRAME_WORDS_PER_LINE = 40;
    localparam int                    FRAME_LINES          = 30;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/vram_fetcher_fifo.sv
// First-word-fall-through synchronous FIFO.
//   clock, reset : posedge clock, synchronous active-high reset
//   push         : write push_data this cycle
//   push_data    : entry to write
//   pop          : remove the head entry this cycle (ignored when empty)
//   flush        : discard every entry; wins over push and pop
//   head_data    : head entry; holds the last popped entry while empty
//   count        : number of stored entries
//   empty, full  : occupancy flags
module sync_fifo_fwft #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [WIDTH-1:0] held;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // While empty the head keeps showing the last word that left the FIFO.
    assign head_data = empty ? held : storage[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push && !flush) begin
            storage[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            held   <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                held   <= storage[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vram_fetcher.sv
// Streams one frame of words from a fixed memory region (read port B of the
// shared dual-port memory) into a small FWFT FIFO for the pixel generator.
//   clock, reset      : posedge clock, synchronous active-high reset
//   frame_start       : pulse; starts or restarts a frame fetch
//   mem_address       : port B address; a read is issued on the posedge where
//                       it advances, and its data is captured one posedge later
//   mem_write_enable  : tied low
//   mem_write_data    : tied to zero
//   mem_read_data     : port B read data (one-cycle latency)
//   pix_data          : FIFO head word
//   pix_valid         : FIFO non-empty
//   pix_ready         : consumer accepts pix_data
//   line_end          : head word is the last word of a line
//   frame_done        : one-cycle pulse after the last word of the frame is popped
//   underflow         : sticky; consumer asked for data while fetching and the
//                       FIFO was empty
//   fetch_state       : current FSM state, for observation
//
// Handshake: a word transfers on every posedge where pix_valid and pix_ready
// are both high; pix_data and line_end stay stable while pix_valid is high and
// pix_ready is low. pix_ready while pix_valid is low has no effect.
module vram_fetcher
    import vram_fetcher_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = FRAME_BASE_ADDR,
    parameter int                    WORDS_PER_LINE = FRAME_WORDS_PER_LINE,
    parameter int                    LINES          = FRAME_LINES,
    parameter int                    FIFO_DEPTH     = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  frame_start,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_write_enable,
    output logic [WORD_WIDTH-1:0] mem_write_data,
    input  logic [WORD_WIDTH-1:0] mem_read_data,
    output logic [WORD_WIDTH-1:0] pix_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  line_end,
    output logic                  frame_done,
    output logic                  underflow,
    output fetch_state_t          fetch_state
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int WC_W  = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam int LC_W  = (LINES > 1) ? $clog2(LINES) : 1;

    localparam logic [WC_W-1:0]  LAST_WORD   = WC_W'(WORDS_PER_LINE - 1);
    localparam logic [LC_W-1:0]  LAST_LINE   = LC_W'(LINES - 1);
    localparam logic [CNT_W:0]   DEPTH_LIMIT = (CNT_W + 1)'(FIFO_DEPTH);

    fetch_state_t state;
    fetch_state_t state_next;

    logic [WC_W-1:0]     word_count;
    logic [LC_W-1:0]     line_count;
    logic                inflight;
    logic                inflight_tag;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_empty;
    logic                fifo_full;
    logic [WORD_WIDTH:0] head_entry;
    logic [CNT_W:0]      occupancy;
    logic                pop;
    logic                push;
    logic                issue;
    logic                last_issue;
    logic                last_pop;

    assign mem_write_enable = 1'b0;
    assign mem_write_data   = '0;
    assign fetch_state      = state;

    assign pix_valid = !fifo_empty;
    assign pix_data  = head_entry[WORD_WIDTH-1:0];
    assign line_end  = pix_valid && head_entry[WORD_WIDTH];
    assign pop       = pix_valid && pix_ready;

    // A restart throws away the word that is still on its way back.
    assign push = inflight && !frame_start;

    // Counting the outstanding read guarantees its data always has a slot.
    assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        last_issue = 1'b0;
        last_pop   = 1'b0;
        case (state)
            FETCH: begin
                issue      = !frame_start && (occupancy < DEPTH_LIMIT);
                last_issue = issue && (word_count == LAST_WORD) && (line_count == LAST_LINE);
                if (last_issue) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Nothing more can arrive once the in-flight flag is clear.
                last_pop = pop && (fifo_count == CNT_W'(1)) && !inflight;
                if (last_pop) begin
                    state_next = IDLE;
                end
            end
            default: ;
        endcase
        // A restart overrides everything, including a frame that just finished.
        if (frame_start) begin
            state_next = FETCH;
            last_pop   = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mem_address  <= BASE_ADDR;
            word_count   <= '0;
            line_count   <= '0;
            inflight     <= 1'b0;
            inflight_tag <= 1'b0;
            frame_done   <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            frame_done <= last_pop;
            if (frame_start) begin
                mem_address <= BASE_ADDR;
                word_count  <= '0;
                line_count  <= '0;
                inflight    <= 1'b0;
                underflow   <= 1'b0;
            end else begin
                inflight <= issue;
                if (issue) begin
                    inflight_tag <= (word_count == LAST_WORD);
                    mem_address  <= mem_address + 1'b1;
                    if (word_count == LAST_WORD) begin
                        word_count <= '0;
                        line_count <= line_count + 1'b1;
                    end else begin
                        word_count <= word_count + 1'b1;
                    end
                end
                if (pix_ready && !pix_valid && (state == FETCH)) begin
                    underflow <= 1'b1;
                end
            end
        end
    end

    sync_fifo_fwft #(
        .WIDTH (WORD_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data ({inflight_tag, mem_read_data}),
        .pop       (pop),
        .flush     (frame_start),
        .head_data (head_entry),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_vram_fetcher.sv
module tb_vram_fetcher;
    import vram_fetcher_pkg::*;

    localparam logic [15:0] BASE  = 16'h0100;
    localparam int          WPL   = 4;
    localparam int          NLINE = 2;
    localparam int          DEPTH = 4;

    logic         clock;
    logic         reset;
    logic         frame_start;
    logic [15:0]  mem_address;
    logic         mem_write_enable;
    logic [15:0]  mem_write_data;
    logic [15:0]  mem_read_data;
    logic [15:0]  pix_data;
    logic         pix_valid;
    logic         pix_ready;
    logic         line_end;
    logic         frame_done;
    logic         underflow;
    fetch_state_t fetch_state;

    vram_fetcher #(
        .BASE_ADDR      (BASE),
        .WORDS_PER_LINE (WPL),
        .LINES          (NLINE),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .frame_start      (frame_start),
        .mem_address      (mem_address),
        .mem_write_enable (mem_write_enable),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data),
        .pix_data         (pix_data),
        .pix_valid        (pix_valid),
        .pix_ready        (pix_ready),
        .line_end         (line_end),
        .frame_done       (frame_done),
        .underflow        (underflow),
        .fetch_state      (fetch_state)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- memory model ----------------
    // Address sampled on posedge, registered data returned on the negedge.
    logic [15:0] mem_addr_q;
    always @(posedge clock) mem_addr_q <= mem_address;
    always @(negedge clock) mem_read_data <= mem_addr_q ^ 16'hA5A5;

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [15:0] data;
        logic        line_end;
    } vec_t;

    vec_t        tbl [8];
    logic [16:0] exp_q [$];

    int vectors_applied = 0;
    int miscompares     = 0;
    int cyc             = 0;
    int issued          = 0;
    int pops            = 0;
    int done_cnt        = 0;
    int done_cyc        = 0;
    int last_pop_cyc    = 0;
    int first_issue_cyc = 0;
    int last_issue_cyc  = 0;
    logic [15:0] prev_addr = 16'h0100;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors_applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: address stepping, issue-rule bound, popped-word order, done pulses.
    initial begin
        logic [15:0] nxt;
        logic [16:0] exp_word;
        forever begin
            @(negedge clock);
            cyc++;
            if (reset || frame_start) begin
                issued    = 0;
                pops      = 0;
                prev_addr = BASE;
            end else begin
                if (mem_address != prev_addr) begin
                    nxt = prev_addr + 16'd1;
                    check("addr_step", mem_address, nxt);
                    if (issued == 0) first_issue_cyc = cyc;
                    last_issue_cyc = cyc;
                    issued++;
                    prev_addr = mem_address;
                end
                check("occupancy_le_depth", ((issued - pops) <= DEPTH), 1);
                if (pix_valid && pix_ready) begin
                    check("pop_expected", (exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        exp_word = exp_q.pop_front();
                        check("pop_word", {line_end, pix_data}, exp_word);
                        pops++;
                        if (exp_q.size() == 0) last_pop_cyc = cyc;
                    end
                end
            end
            if (frame_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic load_expected();
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back({tbl[i].line_end, tbl[i].data});
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check("drain_in_budget", exp_q.size(), 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n;
        int done_base;

        tbl[0] = '{16'hA4A5, 1'b0};
        tbl[1] = '{16'hA4A4, 1'b0};
        tbl[2] = '{16'hA4A7, 1'b0};
        tbl[3] = '{16'hA4A6, 1'b1};
        tbl[4] = '{16'hA4A1, 1'b0};
        tbl[5] = '{16'hA4A0, 1'b0};
        tbl[6] = '{16'hA4A3, 1'b0};
        tbl[7] = '{16'hA4A2, 1'b1};

        reset       = 1'b1;
        frame_start = 1'b0;
        pix_ready   = 1'b1;
        repeat (3) step();
        reset = 1'b0;

        // Idle after reset; pix_ready high must be ignored.
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_addr", mem_address, 16'h0100);
            check("idle_valid", pix_valid, 0);
            check("idle_done", frame_done, 0);
            check("idle_underflow", underflow, 0);
        end
        check("idle_no_issue", issued, 0);
        check("reset_pix_data", pix_data, 16'h0000);
        check("reset_line_end", line_end, 0);
        check("mem_we", mem_write_enable, 0);
        check("mem_wdata", mem_write_data, 16'h0000);
        check("idle_state", fetch_state, IDLE);

        // Full-rate stream with pix_ready held high.
        done_base = done_cnt;
        load_expected();
        pulse_start();
        check("stream_addr_at_start", mem_address, 16'h0100);
        step();
        check("stream_first_issue", mem_address, 16'h0101);
        wait_drain(40);
        repeat (3) step();
        check("stream_done_count", done_cnt - done_base, 1);
        check("stream_done_timing", done_cyc - last_pop_cyc, 1);
        check("stream_issued", issued, 8);
        check("stream_consecutive", last_issue_cyc - first_issue_cyc, 7);
        check("stream_end_addr", mem_address, 16'h0108);
        check("stream_end_valid", pix_valid, 0);
        check("stream_end_state", fetch_state, IDLE);

        // Back-pressure: FIFO fills, fetch stalls, then single-step pops.
        pix_ready = 1'b0;
        done_base = done_cnt;
        load_expected();
        pulse_start();
        repeat (12) step();
        check("bp_issued", issued, 4);
        check("bp_stall_addr", mem_address, 16'h0104);
        check("bp_valid", pix_valid, 1);
        check("bp_state", fetch_state, FETCH);
        for (int i = 0; i < 8; i++) begin
            n = 0;
            while (!pix_valid && n < 8) begin
                step();
                n++;
            end
            check("bp_head_valid", pix_valid, 1);
            check("bp_head_data", pix_data, tbl[i].data);
            check("bp_head_line_end", line_end, tbl[i].line_end);
            pix_ready = 1'b1;
            step();
            pix_ready = 1'b0;
        end
        repeat (3) step();
        check("bp_drained", exp_q.size(), 0);
        check("bp_done_count", done_cnt - done_base, 1);
        check("bp_issued_total", issued, 8);
        check("bp_underflow", underflow, 0);

        // Consumer ready toggling every cycle once data is available.
        pix_ready = 1'b0;
        done_base = done_cnt;
        load_expected();
        pulse_start();
        n = 0;
        while (!pix_valid && n < 10) begin
            step();
            n++;
        end
        check("tog_first_valid", pix_valid, 1);
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            pix_ready = ~pix_ready;
            step();
            n++;
        end
        pix_ready = 1'b0;
        check("tog_drained", exp_q.size(), 0);
        repeat (3) step();
        check("tog_underflow", underflow, 0);
        check("tog_done_count", done_cnt - done_base, 1);

        // Restart after the third pop.
        pix_ready = 1'b1;
        done_base = done_cnt;
        load_expected();
        pulse_start();
        n = 0;
        while (pops < 3 && n < 20) begin
            step();
            n++;
        end
        check("abort_three_pops", pops, 3);
        load_expected();
        pulse_start();
        check("abort_flushed", pix_valid, 0);
        check("abort_addr", mem_address, 16'h0100);
        check("abort_state", fetch_state, FETCH);
        wait_drain(40);
        repeat (3) step();
        check("abort_done_count", done_cnt - done_base, 1);
        check("abort_issued", issued, 8);

        // Underflow: ready held high while the FIFO is still empty in FETCH.
        pix_ready = 1'b1;
        load_expected();
        pulse_start();
        check("uf_cleared_by_start", underflow, 0);
        step();
        check("uf_set", underflow, 1);
        wait_drain(40);
        repeat (3) step();
        check("uf_sticky_idle", underflow, 1);
        check("uf_idle_state", fetch_state, IDLE);
        pix_ready = 1'b0;
        load_expected();
        pulse_start();
        check("uf_cleared_restart", underflow, 0);
        repeat (4) step();
        check("uf_stays_clear", underflow, 0);
        check("uf_fifo_filled", pix_valid, 1);

        // Reset in the middle of a frame.
        reset = 1'b1;
        step();
        exp_q.delete();
        check("midreset_valid", pix_valid, 0);
        check("midreset_addr", mem_address, 16'h0100);
        check("midreset_state", fetch_state, IDLE);
        check("midreset_done", frame_done, 0);
        reset = 1'b0;
        repeat (2) step();
        check("postreset_valid", pix_valid, 0);
        check("postreset_addr", mem_address, 16'h0100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, miscompares so far %0d", miscompares);
        $fatal(1, "watchdog expired");
    end

endmodule
